dds_scaler_deadlock_monitor_mc: RTL
===================================

# dds_scaler_deadlock_monitor_mc

Multi-channel, threshold-filtered successor to the single-channel HLS deadlock monitor in the dds_scaler IP. It watches NUM_CH per-instance AXIS block/idle signal pairs, and raises a sticky `block` flag only after some channel has stalled for THRESHOLD consecutive cycles. It records which channels were stalled at detection time and holds that capture until software or a debug controller clears it. It sits beside the dds_scaler HLS top and feeds the status/debug register block.

## Interface
Parameters:
- NUM_CH, default 4: number of monitored channels; legal range 1..32.
- CNT_W, default 16: width of the stall counter.
- THRESHOLD, default 1024: consecutive stalled cycles required to latch; legal range 1..2^CNT_W-1.
- IDX_W, default $clog2(NUM_CH) (minimum 1): width of `first_ch`.

Ports:
- clock, in, 1: single clock; all logic is on its rising edge.
- reset_n, in, 1: asynchronous, active-low reset; deassertion is synchronised externally.
- enable, in, 1: monitoring enable.
- clear, in, 1: single-cycle pulse; releases a latched detection and zeroes the counter.
- axis_block_sigs, in, NUM_CH: per-channel AXIS blocked indication.
- inst_idle_sigs, in, NUM_CH: per-channel instance idle; an idle channel is never counted as stalled.
- block, out, 1: sticky deadlock flag.
- block_live, out, 1: registered, unfiltered "any channel stalled" indication.
- block_ch, out, NUM_CH: stall mask captured at latch time.
- first_ch, out, IDX_W: lowest set index of `block_ch`.
- stall_cnt, out, CNT_W: current consecutive-stall count.

## Operation
- Per channel: stall[i] = axis_block_sigs[i] & ~inst_idle_sigs[i]. The combined stall signal is any_stall = OR over all stall[i].
- The FSM has three states: IDLE, WATCH and LATCHED.
- IDLE:
  - stall_cnt = 0.
  - If enable & any_stall: stall_cnt ← 1.
    - If THRESHOLD == 1, go to LATCHED and capture.
    - Otherwise go to WATCH.
- WATCH:
  - If !enable or !any_stall: go to IDLE, stall_cnt ← 0.
  - Else stall_cnt ← stall_cnt+1.
    - If stall_cnt+1 == THRESHOLD, go to LATCHED and capture.
- Capture, on the transition edge:
  - block_ch ← stall vector.
  - first_ch ← lowest index i with stall[i] set.
  - block ← 1.
- LATCHED:
  - block, block_ch and first_ch are held.
  - stall_cnt is frozen at THRESHOLD.
  - Input changes and enable are ignored.
- clear:
  - Takes priority over every other transition.
  - Next state is IDLE; stall_cnt, block, block_ch and first_ch all go to 0.
  - A stall sampled in the same cycle as clear is discarded; counting restarts on the next sampled stall.
- block_live ← enable & any_stall, registered every cycle regardless of state. This is the same one-cycle behaviour as the previous-generation monitor.
- Arithmetic: stall_cnt never exceeds THRESHOLD, so no wrap is possible. Elaboration must fail if THRESHOLD is 0 or ≥ 2^CNT_W.

## Timing
- Reset values (asynchronous):
  - state = IDLE.
  - block = 0, block_live = 0, block_ch = 0, first_ch = 0, stall_cnt = 0.
- Latency: if the first stalled sample is at edge k, block rises after edge k+THRESHOLD-1.
  - THRESHOLD=1 gives one cycle of latency, identical to the previous generation.
- block_live lags the inputs by exactly one cycle.
- Any single non-stalled cycle (or enable low) in WATCH restarts counting from 0.
- Channel switching does not reset the count: if the stall moves from channel 1 to channel 2 with no gap, counting continues.
- Reset asserted mid-WATCH or in LATCHED returns all outputs to reset values immediately, with no clock required.
- clear and a latching condition in the same cycle: clear wins, and block stays 0.

## Test plan
- Reset: hold reset_n=0 with all inputs toggling.
  - Every output reads 0.
  - Release reset with no stall; outputs stay 0.
- THRESHOLD=4, NUM_CH=4:
  - Drive axis_block_sigs=4'b0100, inst_idle_sigs=0 for 4 cycles → block=1 on the 4th edge, block_ch=4'b0100, first_ch=2, stall_cnt=4.
  - Stays latched after inputs drop.
- THRESHOLD=4:
  - Stall for 3 cycles, 1 cycle gap, then 3 cycles → block never asserts; stall_cnt peaks at 3 and returns to 0 on the gap.
  - block_live follows the inputs with 1-cycle lag.
- Idle masking:
  - axis_block_sigs=4'b1111 with inst_idle_sigs=4'b1111 for 100 cycles → block=0 and block_live=0.
  - Then set inst_idle_sigs=4'b1001 → latch with block_ch=4'b0110, first_ch=1.
- Clear priority:
  - Pulse clear on the cycle the 4th stall is sampled → block remains 0 and stall_cnt=0.
  - Later, clear while LATCHED → all capture outputs 0 the next cycle.
- THRESHOLD=1 and mid-operation reset:
  - A single stall cycle on channel 0 latches after one edge.
  - Assert reset_n=0 asynchronously mid-cycle while latched → block drops immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/dds_scaler_deadlock_monitor_mc.sv
// Multi-channel AXIS deadlock monitor: latches a sticky block flag once any
// non-idle channel has stayed blocked for THRESHOLD consecutive cycles.
module dds_scaler_deadlock_monitor_mc #(
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = 16,
  parameter int THRESHOLD = 1024,
  parameter int IDX_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              clear,
  input  logic [NUM_CH-1:0] axis_block_sigs,
  input  logic [NUM_CH-1:0] inst_idle_sigs,
  output logic              block,
  output logic              block_live,
  output logic [NUM_CH-1:0] block_ch,
  output logic [IDX_W-1:0]  first_ch,
  output logic [CNT_W-1:0]  stall_cnt
);

  if (THRESHOLD < 1 || 64'(THRESHOLD) >= (64'd1 << CNT_W)) begin : g_bad_threshold
    $error("THRESHOLD must lie in 1..2^CNT_W-1");
  end
  if (NUM_CH < 1 || NUM_CH > 32) begin : g_bad_num_ch
    $error("NUM_CH must lie in 1..32");
  end

  localparam logic [CNT_W-1:0] ThreshC = CNT_W'(THRESHOLD);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WATCH   = 2'd1,
    LATCHED = 2'd2
  } state_e;

  state_e             stateQ, stateD;
  logic [CNT_W-1:0]   cntQ, cntD;
  logic               blockQ, blockD;
  logic               liveQ, liveD;
  logic [NUM_CH-1:0]  chQ, chD;
  logic [IDX_W-1:0]   firstQ, firstD;

  logic [NUM_CH-1:0]  stall;
  logic               anyStall;
  logic [IDX_W-1:0]   lowIdx;

  assign stall    = axis_block_sigs & ~inst_idle_sigs;
  assign anyStall = |stall;

  // Descending scan so the lowest set index is the one left standing.
  always_comb begin
    lowIdx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (stall[i]) lowIdx = IDX_W'(i);
    end
  end

  always_comb begin
    stateD = stateQ;
    cntD   = cntQ;
    blockD = blockQ;
    chD    = chQ;
    firstD = firstQ;
    liveD  = enable & anyStall;

    if (clear) begin
      stateD = IDLE;
      cntD   = '0;
      blockD = 1'b0;
      chD    = '0;
      firstD = '0;
    end else begin
      case (stateQ)
        IDLE: begin
          cntD = '0;
          if (enable && anyStall) begin
            cntD = CNT_W'(1);
            if (THRESHOLD == 1) begin
              stateD = LATCHED;
              blockD = 1'b1;
              chD    = stall;
              firstD = lowIdx;
            end else begin
              stateD = WATCH;
            end
          end
        end
        WATCH: begin
          if (!enable || !anyStall) begin
            stateD = IDLE;
            cntD   = '0;
          end else begin
            cntD = cntQ + CNT_W'(1);
            if (cntQ + CNT_W'(1) == ThreshC) begin
              stateD = LATCHED;
              blockD = 1'b1;
              chD    = stall;
              firstD = lowIdx;
            end
          end
        end
        LATCHED: begin
          cntD = ThreshC;
        end
        default: begin
          stateD = IDLE;
          cntD   = '0;
          blockD = 1'b0;
          chD    = '0;
          firstD = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stateQ <= IDLE;
      cntQ   <= '0;
      blockQ <= 1'b0;
      liveQ  <= 1'b0;
      chQ    <= '0;
      firstQ <= '0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
      blockQ <= blockD;
      liveQ  <= liveD;
      chQ    <= chD;
      firstQ <= firstD;
    end
  end

  assign block      = blockQ;
  assign block_live = liveQ;
  assign block_ch   = chQ;
  assign first_ch   = firstQ;
  assign stall_cnt  = cntQ;

endmodule
